// File: rtl/regfile_wb_if.sv
// Writeback/read bundle for regfile_wb.
// Writeback side: we, waddr, wdata (registered MEM/WB triple).
// Read side: re1/raddr1 -> rdata1 and re2/raddr2 -> rdata2 (combinational).
// Status: init_busy, high while the post-reset clear runs.
// master = pipeline/decode side, slave = register file.
interface regfile_wb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              init_busy;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, init_busy
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, init_busy
  );
endinterface

// File: rtl/regfile_wb.sv
// General-purpose register file fed by the MEM/WB writeback stage.
// Ports: clk (rising edge), rst (synchronous, active-high),
//        wb (regfile_wb_if.slave): writeback triple in, two combinational
//        read ports out, init_busy out.
// After reset every entry is written to zero, one per cycle, while
// init_busy is high; writebacks are ignored and reads return 0 meanwhile.
// Register 0 always reads 0. A read of the register being written in the
// same cycle returns the incoming writeback data (bypass).

// One combinational read port.
module regfile_wb_rd #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              blank,    // reset or clear sequence in progress
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_word, // storage contents at raddr
  output logic [DATA_W-1:0] rdata
);
  always_comb begin
    rdata = '0;
    if (blank)                            rdata = '0;
    else if (raddr == '0)                 rdata = '0;
    else if (re && we && raddr == waddr)  rdata = wdata;
    else if (re)                          rdata = mem_word;
  end
endmodule

module regfile_wb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic          clk,
  input  logic          rst,
  regfile_wb_if.slave   wb
);
  localparam int NRD = 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              init_busy_q;
  logic [DATA_W-1:0] mem [NREG];

  // Clear sequencer: NREG cycles of INIT, leaving on the edge that clears
  // the last entry so clr_cnt never has to wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      clr_cnt     <= '0;
      init_busy_q <= 1'b1;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (clr_cnt == ADDR_W'(NREG - 1)) begin
        state       <= RUN;
        init_busy_q <= 1'b0;
      end
    end
  end

  // Storage has no reset; the clear sequence is what zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        mem[clr_cnt] <= '0;
      else if (wb.we && wb.waddr != '0)
        mem[wb.waddr] <= wb.wdata;
    end
  end

  logic                           blank;
  logic [NRD-1:0]                 re;
  logic [NRD-1:0][ADDR_W-1:0]     raddr;
  logic [NRD-1:0][DATA_W-1:0]     mem_rd;
  logic [NRD-1:0][DATA_W-1:0]     rdata;

  assign blank = rst | init_busy_q;
  assign re    = {wb.re2, wb.re1};
  assign raddr = {wb.raddr2, wb.raddr1};

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign mem_rd[g] = mem[raddr[g]];
    regfile_wb_rd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd (
      .blank    (blank),
      .re       (re[g]),
      .raddr    (raddr[g]),
      .we       (wb.we),
      .waddr    (wb.waddr),
      .wdata    (wb.wdata),
      .mem_word (mem_rd[g]),
      .rdata    (rdata[g])
    );
  end

  assign wb.rdata1    = rdata[0];
  assign wb.rdata2    = rdata[1];
  assign wb.init_busy = init_busy_q;
endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0;
    bus.re2 = 1'b0; bus.raddr2 = '0;
  endtask

  // Counts cycles with init_busy high, bounded so a stuck sequencer ends.
  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 200 && bus.init_busy === 1'b1; k++) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    int bad;
    logic [DATA_W-1:0] exp1, exp2;
    idle();
    rst = 1'b1;
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd6;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hCAFE0001;
    tick();
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: rdata1=%h rdata2=%h want 0", bus.rdata1, bus.rdata2);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (bus.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: init_busy=%b want 1", bus.init_busy);
    end
    // reads during INIT must be 0 even with a matching writeback present
    n = 0; bad = 0;
    for (int k = 0; k < 200 && bus.init_busy === 1'b1; k++) begin
      #1;
      if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) bad++;
      n++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_rdata: %0d nonzero read cycles want 0", bad);
    end
    checks++;
    if (n != NREG) begin
      errors++;
      $display("FAIL init_len: busy %0d cycles want %0d", n, NREG);
    end
    idle();
    for (int i = 1; i < NREG; i++) begin
      bus.re1 = 1'b1; bus.raddr1 = ADDR_W'(i);
      bus.re2 = 1'b1; bus.raddr2 = ADDR_W'(NREG - i);
      #1;
      exp1 = 32'h0; exp2 = 32'h0;
      checks++;
      if (bus.rdata1 !== exp1 || bus.rdata2 !== exp2) begin
        errors++;
        $display("FAIL clear_reg%0d: rdata1=%h rdata2=%h want 0", i, bus.rdata1, bus.rdata2);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    tick();
    idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    #1;
    checks++;
    if (bus.rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read: rdata1=%h want deadbeef", bus.rdata1);
    end
    bus.re1 = 1'b0;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL read_disabled: rdata1=%h want 0", bus.rdata1);
    end
    idle();
  endtask

  task automatic test_bypass();
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h12345678 || bus.rdata2 !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass: rdata1=%h rdata2=%h want 12345678", bus.rdata1, bus.rdata2);
    end
    // bypass is gated by the read enable
    bus.re1 = 1'b0;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_re: rdata1=%h rdata2=%h want 0/12345678", bus.rdata1, bus.rdata2);
    end
    bus.re1 = 1'b1;
    tick();
    bus.we = 1'b0; bus.wdata = 32'h0;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h12345678 || bus.rdata2 !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_stored: rdata1=%h rdata2=%h want 12345678", bus.rdata1, bus.rdata2);
    end
    idle();
  endtask

  task automatic test_reg_zero();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass: rdata1=%h rdata2=%h want 0", bus.rdata1, bus.rdata2);
    end
    tick();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_stored: rdata1=%h rdata2=%h want 0", bus.rdata1, bus.rdata2);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v;
    // write regs 1..4 on consecutive cycles; port1 bypasses the current
    // write, port2 reads the previous one back from storage
    for (int i = 1; i <= 4; i++) begin
      bus.we = 1'b1; bus.waddr = ADDR_W'(i); bus.wdata = 32'h01010101 * i;
      bus.re1 = 1'b1; bus.raddr1 = ADDR_W'(i);
      bus.re2 = 1'b1; bus.raddr2 = ADDR_W'(i - 1);
      #1;
      v = (i == 1) ? 32'h0 : 32'h01010101 * (i - 1);
      checks++;
      if (bus.rdata1 !== 32'h01010101 * i || bus.rdata2 !== v) begin
        errors++;
        $display("FAIL b2b_%0d: rdata1=%h rdata2=%h want %h/%h", i, bus.rdata1, bus.rdata2,
                 32'h01010101 * i, v);
      end
      tick();
    end
    idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd4;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h04040404 || bus.rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_final: rdata1=%h rdata2=%h want 04040404/deadbeef", bus.rdata1, bus.rdata2);
    end
    idle();
  endtask

  task automatic test_init_write_ignored();
    int n;
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h00000011;
    tick();
    rst = 1'b1;
    bus.wdata = 32'hA5A5A5A5;
    tick();
    rst = 1'b0;
    bus.re2 = 1'b1; bus.raddr2 = 5'd3;
    wait_init(n);
    checks++;
    if (n != NREG) begin
      errors++;
      $display("FAIL initw_len: busy %0d cycles want %0d", n, NREG);
    end
    bus.we = 1'b0; bus.wdata = 32'h0;
    #1;
    checks++;
    if (bus.rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL init_write_ignored: rdata2=%h want 0", bus.rdata2);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(n);
    checks++;
    if (n != NREG) begin
      errors++;
      $display("FAIL mid_init_len: busy %0d cycles want %0d", n, NREG);
    end
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h00000055;
    tick();
    idle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd9;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h00000055) begin
      errors++;
      $display("FAIL mid_run_write: rdata1=%h want 00000055", bus.rdata1);
    end
    // write presented alongside rst is discarded
    rst = 1'b1;
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h00000077;
    tick();
    rst = 1'b0;
    bus.we = 1'b0;
    wait_init(n);
    checks++;
    if (n != NREG) begin
      errors++;
      $display("FAIL mid_run_len: busy %0d cycles want %0d", n, NREG);
    end
    bus.re1 = 1'b1; bus.raddr1 = 5'd9;
    #1;
    checks++;
    if (bus.rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL mid_run_clear: rdata1=%h want 0", bus.rdata1);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_reg_zero();
    test_back_to_back();
    test_init_write_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- General-purpose register file at the consuming end of the writeback interface.
- Accepts the registered writeback triple (write enable, address, data) from the MEM/WB pipeline stage.
- Serves two combinational read ports to the decode stage.
- Provides same-cycle write-to-read bypass, hardwires register 0 to zero, and runs a sequenced post-reset clear of all entries, signalled by init_busy.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREG, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- we  input  1  writeback write enable.
- waddr  input  ADDR_W  writeback destination register.
- wdata  input  DATA_W  writeback data.
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1 (combinational).
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2 (combinational).
- init_busy  output  1  high while the post-reset clear sequence runs.

Behaviour:
- Reset (rst=1 sampled at a rising clk edge):
  - state<=INIT, clr_cnt<=0, init_busy<=1.
  - Storage is not cleared by reset directly.
  - While rst=1, rdata1=rdata2=0 combinationally.
- State INIT:
  - Each cycle: mem[clr_cnt]<=0, clr_cnt<=clr_cnt+1.
  - When clr_cnt==NREG-1, the final clear occurs, state<=RUN and init_busy<=0 on that edge.
  - Total: init_busy high for exactly NREG cycles after rst deasserts.
  - Writeback inputs are ignored during INIT; upstream holds the pipeline via init_busy.
  - Reads in INIT return 0 on both ports.
- State RUN:
  - On a rising edge with we=1 and waddr!=0: mem[waddr]<=wdata.
  - we=1 with waddr==0 is dropped silently.
  - RUN persists until the next rst.
- Read port n (n=1,2), priority order, combinational:
  1. rst=1 or init_busy=1 -> 0.
  2. raddrn==0 -> 0.
  3. ren=1 and we=1 and raddrn==waddr -> wdata (bypass, same cycle).
  4. ren=1 -> mem[raddrn].
  5. ren=0 -> 0.
- Both ports are independent. Identical addresses on both ports return identical data, including under bypass.
- Write latency: data is visible through storage from the cycle after the edge, and through bypass in the same cycle.
- Reset mid-INIT: clr_cnt restarts at 0 and the full NREG-cycle clear repeats.
- Reset mid-RUN: a write presented in the same cycle as rst is discarded.
- clr_cnt is ADDR_W bits wide and must not wrap before the INIT->RUN transition is taken.
- No X may propagate to rdata1/rdata2 after init_busy falls: every entry is written 0 by the clear sequence.

Test Plan:
- Reset sequencing: pulse rst 2 cycles, then low -> init_busy=1 for exactly 32 cycles, then 0; rdata1/rdata2=0 throughout; afterwards reading each of regs 1..31 returns 0x00000000.
- Write then read: in RUN, write we=1 waddr=5 wdata=0xDEADBEEF; next cycle re1=1 raddr1=5 -> rdata1=0xDEADBEEF; re1=0 -> rdata1=0.
- Bypass: same cycle, we=1 waddr=7 wdata=0x12345678, re1=re2=1, raddr1=raddr2=7 -> both read 0x12345678 before the edge; both read the same value afterwards from storage.
- Register zero: write we=1 waddr=0 wdata=0xFFFFFFFF -> raddr1=0 reads 0, also during the bypass cycle.
- Write ignored in INIT: rst then, during INIT, we=1 waddr=3 wdata=0xA5A5A5A5 -> after init_busy falls, raddr2=3 reads 0.
- Reset mid-INIT and mid-RUN: assert rst at INIT cycle 10 -> init_busy stays high a further 32 cycles after release. Write 0x55 to reg 9 in RUN, then reset -> after the clear, reg 9 reads 0.
